// File: rtl/ddr_app_responder.sv
// ddr_app_responder: on-chip stand-in for the DDR3 user application interface.
// Serves write/read bursts from a 128-bit word array, models calibration delay,
// command back-pressure and read latency, and aliases address bits above the
// array index so initiator size-detect logic sees a wrapped memory.
module ddr_app_responder #(
    parameter int DEPTH_LOG2   = 10,
    parameter int CALIB_CYCLES = 200,
    parameter int READ_LATENCY = 4,
    parameter int CMD_GAP      = 2,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic         clk_x1,
    input  logic         rst_n,
    input  logic [26:0]  app_addr,
    input  logic         app_cmd_en,
    input  logic [2:0]   app_cmd,
    output logic         app_cmd_rdy,
    input  logic [5:0]   app_burst_number,
    input  logic         app_wren,
    input  logic [127:0] app_data,
    input  logic         app_data_end,
    output logic         app_data_rdy,
    output logic         app_rdata_valid,
    output logic         app_rdata_end,
    output logic [127:0] app_rdata,
    output logic         init_calib_complete,
    output logic         proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [31:0]    CALIB_LAST = 32'(CALIB_CYCLES - 1);
    localparam logic [31:0]    RDW_LAST   = 32'(READ_LATENCY - 2);
    localparam logic [31:0]    GAP_LAST   = (CMD_GAP > 0) ? 32'(CMD_GAP - 1) : 32'd0;
    localparam logic [PTR_W:0] FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_CALIB   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_READ    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    state_t                  state_r;
    logic [31:0]             cnt_r;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [5:0]              burst_r;
    logic [5:0]              beat_r;
    logic                    calib_done_r;
    logic                    cmd_rdy_r;
    logic                    rdata_valid_r;
    logic [127:0]            rdata_r;
    logic                    proto_err_r;
    logic                    data_rdy_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W:0]          count_r;
    logic [PTR_W:0]          count_next_s;
    logic [127:0]            mem_r [WORDS];
    logic [127:0]            fifo_mem_r [FIFO_DEPTH];

    logic push_s;
    logic pop_s;
    logic calib_hit_s;
    logic cmd_fire_s;
    logic bad_cmd_s;
    logic unused_s;

    assign push_s      = app_wren & data_rdy_r;
    assign pop_s       = (state_r == ST_WRITE) & (count_r != {(PTR_W + 1){1'b0}});
    assign calib_hit_s = (state_r == ST_CALIB) & (cnt_r == CALIB_LAST);
    assign cmd_fire_s  = app_cmd_en & cmd_rdy_r;
    assign bad_cmd_s   = (app_cmd != 3'h0) & (app_cmd != 3'h1);
    // Data-end strobe and address bits outside the word index carry no meaning here.
    assign unused_s    = ^{app_data_end, app_addr};

    assign app_cmd_rdy         = cmd_rdy_r;
    assign app_data_rdy        = data_rdy_r;
    assign app_rdata_valid     = rdata_valid_r;
    assign app_rdata_end       = rdata_valid_r;
    assign app_rdata           = rdata_r;
    assign init_calib_complete = calib_done_r;
    assign proto_err           = proto_err_r;

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{PTR_W{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Write-data FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_x1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W + 1){1'b0}};
            data_rdy_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            count_r    <= count_next_s;
            data_rdy_r <= (calib_done_r | calib_hit_s) & (count_next_s < FIFO_FULL);
        end
    end

    // FIFO storage; no reset so it maps onto RAM.
    always_ff @(posedge clk_x1) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= app_data;
        end
    end

    // Main array write port, fed straight from the FIFO head; contents survive reset.
    always_ff @(posedge clk_x1) begin
        if (pop_s) begin
            mem_r[idx_r] <= fifo_mem_r[rd_ptr_r];
        end
    end

    // Command state machine: calibration, burst sequencing, read beats and gap.
    always_ff @(posedge clk_x1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_CALIB;
            cnt_r         <= 32'd0;
            idx_r         <= {DEPTH_LOG2{1'b0}};
            burst_r       <= 6'd0;
            beat_r        <= 6'd0;
            calib_done_r  <= 1'b0;
            cmd_rdy_r     <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_r       <= 128'd0;
        end else begin
            rdata_valid_r <= 1'b0;
            case (state_r)
                ST_CALIB: begin
                    if (cnt_r == CALIB_LAST) begin
                        calib_done_r <= 1'b1;
                        cmd_rdy_r    <= 1'b1;
                        cnt_r        <= 32'd0;
                        state_r      <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (app_cmd_en) begin
                        idx_r     <= app_addr[3 +: DEPTH_LOG2];
                        burst_r   <= app_burst_number;
                        beat_r    <= 6'd0;
                        cnt_r     <= 32'd0;
                        cmd_rdy_r <= 1'b0;
                        case (app_cmd)
                            3'h0:    state_r <= ST_WRITE;
                            3'h1:    state_r <= ST_RD_WAIT;
                            default: state_r <= ST_GAP;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (pop_s) begin
                        idx_r  <= idx_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
                        beat_r <= beat_r + 6'd1;
                        if (beat_r == burst_r) begin
                            state_r <= ST_GAP;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // Pads latency so the first beat lands READ_LATENCY edges after acceptance.
                    if (cnt_r == RDW_LAST) begin
                        cnt_r   <= 32'd0;
                        state_r <= ST_READ;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_READ: begin
                    rdata_valid_r <= 1'b1;
                    rdata_r       <= mem_r[idx_r];
                    idx_r         <= idx_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
                    beat_r        <= beat_r + 6'd1;
                    if (beat_r == burst_r) begin
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_r >= GAP_LAST) begin
                        cnt_r     <= 32'd0;
                        cmd_rdy_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    cnt_r     <= 32'd0;
                    cmd_rdy_r <= 1'b0;
                    state_r   <= ST_GAP;
                end
            endcase
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk_x1 or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r <= 1'b0;
        end else if ((app_cmd_en & ~cmd_rdy_r) | (app_wren & ~data_rdy_r) |
                     (cmd_fire_s & bad_cmd_s)) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

endmodule
